// File: rtl/el2_ifu_ghr_ctl.sv
// Global branch history control: speculative and committed GHRs plus a FIFO of
// outstanding predicted directions. Optional mispredict counter: EL2_GHR_MISPRED_CNT_EN.
module el2_ifu_ghr_ctl #(
  parameter int GHR_SIZE   = 8,
  parameter int CKPT_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pred_valid,
  input  logic                          pred_taken,
  output logic                          pred_ready,
  input  logic                          res_valid,
  input  logic                          res_taken,
  input  logic                          flush,
  output logic [GHR_SIZE-1:0]           ghr_spec,
  output logic [GHR_SIZE-1:0]           ghr_commit,
  output logic                          res_mispred,
  output logic [$clog2(CKPT_DEPTH):0]   ckpt_count,
  output logic                          ghr_err,
  output logic [15:0]                   mispred_cnt
);

  localparam int PW = $clog2(CKPT_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(CKPT_DEPTH);

  logic [CKPT_DEPTH-1:0] ckpt_q;
  logic [PW-1:0]         wr_ptr, rd_ptr;

  logic                  accept, push, res_pop, res_empty, mispred, restore, head;
  logic [GHR_SIZE-1:0]   commit_next, spec_next;
  logic [CW-1:0]         count_next;
  logic [PW-1:0]         wr_ptr_next, rd_ptr_next;

  // Handshake: a prediction transfers on a cycle where pred_valid & pred_ready;
  // pred_ready ignores any same-cycle pop, so a full FIFO always stalls fetch.
  assign pred_ready = (ckpt_count != DEPTH_C) & ~flush;
  assign accept     = pred_valid & pred_ready;
  assign head       = ckpt_q[rd_ptr];
  assign res_empty  = res_valid & (ckpt_count == '0);
  assign res_pop    = res_valid & (ckpt_count != '0);
  assign mispred    = res_pop & (res_taken != head);
  // Any event that makes the speculative history untrustworthy rebuilds it from commit.
  assign restore    = mispred | res_empty | flush;
  assign push       = accept & ~restore;

  always_comb begin
    commit_next = ghr_commit;
    spec_next   = ghr_spec;
    count_next  = ckpt_count;
    wr_ptr_next = wr_ptr;
    rd_ptr_next = rd_ptr;
    if (res_valid) commit_next = {ghr_commit[GHR_SIZE-2:0], res_taken};
    if (restore) begin
      spec_next   = commit_next;
      count_next  = '0;
      wr_ptr_next = '0;
      rd_ptr_next = '0;
    end else begin
      if (push) begin
        spec_next   = {ghr_spec[GHR_SIZE-2:0], pred_taken};
        wr_ptr_next = wr_ptr + PW'(1);
      end
      if (res_pop) rd_ptr_next = rd_ptr + PW'(1);
      case ({push, res_pop})
        2'b10:   count_next = ckpt_count + CW'(1);
        2'b01:   count_next = ckpt_count - CW'(1);
        default: count_next = ckpt_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_spec    <= '0;
      ghr_commit  <= '0;
      ckpt_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      res_mispred <= 1'b0;
      ghr_err     <= 1'b0;
    end else begin
      ghr_spec    <= spec_next;
      ghr_commit  <= commit_next;
      ckpt_count  <= count_next;
      wr_ptr      <= wr_ptr_next;
      rd_ptr      <= rd_ptr_next;
      res_mispred <= mispred;
      ghr_err     <= ghr_err | res_empty;
    end
  end

  // Storage needs no reset: entries are only read while counted as valid.
  always_ff @(posedge clk) begin
    if (push) ckpt_q[wr_ptr] <= pred_taken;
  end

`ifdef EL2_GHR_MISPRED_CNT_EN
  logic [15:0] cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                cnt_q <= '0;
    else if (mispred && cnt_q != 16'hFFFF)  cnt_q <= cnt_q + 16'd1;
  end
  assign mispred_cnt = cnt_q;
`else
  assign mispred_cnt = 16'h0;
`endif

endmodule
